sd_sync_sched: RTL

- Timing controller and line-buffer scheduler for the ZX81 VGA scandoubler.
- Decodes the composite sync into line and frame events and locks onto the incoming line rate.
- Generates the write and read addresses and enables for the two-bank (2x512x1) line buffer, plus line, column and scanline state for the output stage.
- Free-runs synthetic lines if sync is lost, so the VGA monitor never sees a dropped hsync.

---
 rtl/sd_pkg.sv | 18 +
 rtl/sd_sync_class.sv | 43 ++++
 rtl/sd_sync_sched.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/sd_pkg.sv
// Shared timing constants and controller state type for the ZX81 VGA scandoubler.
// One zx line is 2*LINE_LEN ce_2pix ticks; the VGA side shows each zx line twice.
package sd_pkg;

  localparam int LINE_LEN   = 414;
  localparam int HS_MIN     = 4;
  localparam int VSYNC_MIN  = 90;
  localparam int TOL        = 8;
  localparam int LOCK_LINES = 3;
  localparam int HS_END     = 384;

  typedef enum logic [1:0] {
    SEARCH,
    LOCKED,
    FREERUN
  } sd_state_t;

endpackage

// File: rtl/sd_sync_class.sv
// Composite sync classifier: measures csync low time and flags hsync and vsync events.
// Events are single-tick strobes already qualified by ce_2pix.
module sd_sync_class
  import sd_pkg::*;
(
  input  logic clkvga,
  input  logic rst_n,
  input  logic ce_2pix,
  input  logic csync,
  output logic hs_evt,
  output logic vs_evt,
  output logic vs_level
);

  logic [7:0] sync_len;
  logic       csd;
  logic       rise;

  // A rise after a long low closes vsync and must not count as a line.
  always_comb begin
    rise   = ce_2pix & csync & ~csd;
    hs_evt = rise && (sync_len >= 8'(HS_MIN)) && (sync_len < 8'(VSYNC_MIN));
    vs_evt = ce_2pix && !csync && (sync_len == 8'(VSYNC_MIN - 1));
  end

  always_ff @(posedge clkvga or negedge rst_n) begin
    if (!rst_n) begin
      csd      <= 1'b0;
      sync_len <= '0;
      vs_level <= 1'b0;
    end else if (ce_2pix) begin
      csd <= csync;
      if (csync) begin
        sync_len <= '0;
        vs_level <= 1'b0;
      end else begin
        if (sync_len != 8'hff) sync_len <= sync_len + 8'd1;
        if (vs_evt) vs_level <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sd_sync_sched.sv
// Line-rate lock FSM and line-buffer scheduler for the scandoubler.
// Write side follows the zx line, read side replays the other bank at double rate.
module sd_sync_sched
  import sd_pkg::*;
(
  input  logic       clkvga,
  input  logic       rst_n,
  input  logic       ce_2pix,
  input  logic       csync,
  output logic       wr_en,
  output logic [9:0] wr_addr,
  output logic [9:0] rd_addr,
  output logic [8:0] sd_col,
  output logic [9:0] line_cnt,
  output logic       hs_out,
  output logic       vs_out,
  output logic       scanline,
  output logic       locked
);

  localparam logic [9:0] ZX_LAST = 10'(2 * LINE_LEN - 1);
  localparam logic [9:0] ZX_END  = 10'(2 * LINE_LEN);
  localparam logic [9:0] TOL_LO  = 10'(2 * LINE_LEN - TOL);
  localparam logic [9:0] TOL_HI  = 10'(2 * LINE_LEN + TOL);
  localparam logic [8:0] SD_LAST = 9'(LINE_LEN - 1);
  localparam logic [1:0] LOCK_AT = 2'(LOCK_LINES - 1);

  logic       hs_evt, vs_evt, vs_level;
  sd_state_t  state, state_nxt;
  logic [1:0] good_cnt, good_nxt;
  logic [9:0] zx_col, zx_nxt, line_nxt;
  logic [8:0] sd_nxt;
  logic       wr_bank, bank_nxt, scan_nxt;
  logic       synth_evt, line_evt, in_tol;

  sd_sync_class u_sync_class (
    .clkvga   (clkvga),
    .rst_n    (rst_n),
    .ce_2pix  (ce_2pix),
    .csync    (csync),
    .hs_evt   (hs_evt),
    .vs_evt   (vs_evt),
    .vs_level (vs_level)
  );

  assign in_tol   = (zx_col >= TOL_LO) && (zx_col <= TOL_HI);
  assign line_evt = hs_evt | synth_evt;

  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    synth_evt = 1'b0;
    case (state)
      SEARCH: begin
        if (hs_evt) begin
          if (in_tol) begin
            good_nxt = good_cnt + 2'd1;
            if (good_cnt == LOCK_AT) state_nxt = LOCKED;
          end else begin
            good_nxt = '0;
          end
        end
      end
      LOCKED: begin
        if (hs_evt) begin
          if (!in_tol) begin
            state_nxt = SEARCH;
            good_nxt  = '0;
          end
        end else if (ce_2pix && zx_col == TOL_HI) begin
          synth_evt = 1'b1;
          state_nxt = FREERUN;
        end
      end
      FREERUN: begin
        if (hs_evt) begin
          state_nxt = SEARCH;
          good_nxt  = 2'd1;
        end else if (ce_2pix && zx_col == ZX_LAST) begin
          synth_evt = 1'b1;
        end
      end
      default: state_nxt = SEARCH;
    endcase
  end

  // A line event outranks the sd_col wrap so scanline toggles once; vsync wins last.
  always_comb begin
    zx_nxt   = zx_col;
    sd_nxt   = sd_col;
    bank_nxt = wr_bank;
    line_nxt = line_cnt;
    scan_nxt = scanline;
    if (line_evt) begin
      zx_nxt   = '0;
      sd_nxt   = '0;
      bank_nxt = ~wr_bank;
      line_nxt = line_cnt + 10'd1;
      scan_nxt = ~scanline;
    end else begin
      if (zx_col != 10'h3ff) zx_nxt = zx_col + 10'd1;
      if (sd_col == SD_LAST) begin
        sd_nxt   = '0;
        scan_nxt = ~scanline;
      end else begin
        sd_nxt = sd_col + 9'd1;
      end
    end
    if (vs_evt) begin
      line_nxt = '0;
      scan_nxt = 1'b0;
    end
  end

  always_ff @(posedge clkvga or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SEARCH;
      good_cnt <= '0;
      zx_col   <= '0;
      sd_col   <= '0;
      wr_bank  <= 1'b0;
      line_cnt <= '0;
      scanline <= 1'b0;
      rd_addr  <= '0;
      hs_out   <= 1'b0;
    end else if (ce_2pix) begin
      state    <= state_nxt;
      good_cnt <= good_nxt;
      zx_col   <= zx_nxt;
      sd_col   <= sd_nxt;
      wr_bank  <= bank_nxt;
      line_cnt <= line_nxt;
      scanline <= scan_nxt;
      rd_addr  <= {~bank_nxt, sd_nxt};
      hs_out   <= (sd_nxt < 9'(HS_END));
    end
  end

  assign wr_en   = ce_2pix & zx_col[0] & (zx_col < ZX_END);
  assign wr_addr = {wr_bank, zx_col[9:1]};
  assign vs_out  = vs_level;
  assign locked  = (state == LOCKED);

endmodule
